// File: rtl/rpn_stack_calc.sv
// RPN evaluator: accepts number/operator tokens over stb/ack, evaluates them on an
// internal stack of WIDTH x DEPTH entries and emits the result or an error code on '='.
module rpn_stack_calc #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             input_stb,
  input  logic [WIDTH-1:0] input_dat,
  input  logic             input_operator,
  output logic             input_ack,
  output logic             output_stb,
  output logic [WIDTH-1:0] output_dat,
  output logic [1:0]       output_err,
  input  logic             output_ack,
  output logic [CW-1:0]    stack_count,
  output logic [1:0]       dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_MUL  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_EQ   = 3'd4;
  localparam logic [2:0] OP_DUP  = 3'd5;
  localparam logic [2:0] OP_SWAP = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_OVER  = 2'd2;
  localparam logic [1:0] ERR_BAD   = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, OUT = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tok_dat_q, tok_dat_d;
  logic             tok_op_q, tok_op_d;
  logic             input_ack_q, input_ack_d;
  logic             output_stb_q, output_stb_d;
  logic [WIDTH-1:0] output_dat_q, output_dat_d;
  logic [1:0]       output_err_q, output_err_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];

  logic [AW-1:0]    push_idx, top_idx, next_idx;
  logic [WIDTH-1:0] top_val, next_val, alu_res;
  logic [1:0]       err_code;

  // Top of stack lives at index count-1; indices are only used when guarded by count.
  assign push_idx = AW'(count_q);
  assign top_idx  = AW'(count_q - CW'(1));
  assign next_idx = AW'(count_q - CW'(2));
  assign top_val  = stack_q[top_idx];
  assign next_val = stack_q[next_idx];

  // Low WIDTH bits of a product are identical for signed and unsigned operands.
  always_comb begin
    alu_res = '0;
    case (tok_dat_q[2:0])
      OP_MUL:  alu_res = next_val * top_val;
      OP_ADD:  alu_res = next_val + top_val;
      OP_SUB:  alu_res = next_val - top_val;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    tok_dat_d    = tok_dat_q;
    tok_op_d     = tok_op_q;
    input_ack_d  = 1'b0;
    output_stb_d = output_stb_q;
    output_dat_d = output_dat_q;
    output_err_d = output_err_q;
    count_d      = count_q;
    stack_d      = stack_q;
    err_code     = ERR_NONE;
    case (state_q)
      IDLE: begin
        if (input_stb && !input_ack_q) begin
          tok_dat_d   = input_dat;
          tok_op_d    = input_operator;
          input_ack_d = 1'b1;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        state_d = IDLE;
        if (!tok_op_q) begin
          if (count_q < CW'(DEPTH)) begin
            stack_d[push_idx] = tok_dat_q;
            count_d           = count_q + CW'(1);
          end else begin
            err_code = ERR_OVER;
          end
        end else begin
          case (tok_dat_q[2:0])
            OP_MUL, OP_ADD, OP_SUB: begin
              if (count_q >= CW'(2)) begin
                stack_d[next_idx] = alu_res;
                count_d           = count_q - CW'(1);
              end else begin
                err_code = ERR_UNDER;
              end
            end
            OP_EQ: begin
              if (count_q == CW'(1)) begin
                output_stb_d = 1'b1;
                output_dat_d = top_val;
                output_err_d = ERR_NONE;
                state_d      = OUT;
              end else if (count_q == '0) begin
                err_code = ERR_UNDER;
              end else begin
                err_code = ERR_BAD;
              end
            end
            OP_DUP: begin
              if (count_q == '0) begin
                err_code = ERR_UNDER;
              end else if (count_q >= CW'(DEPTH)) begin
                err_code = ERR_OVER;
              end else begin
                stack_d[push_idx] = top_val;
                count_d           = count_q + CW'(1);
              end
            end
            OP_SWAP: begin
              if (count_q >= CW'(2)) begin
                stack_d[top_idx]  = next_val;
                stack_d[next_idx] = top_val;
              end else begin
                err_code = ERR_UNDER;
              end
            end
            OP_CLR:  count_d  = '0;
            default: err_code = ERR_BAD;
          endcase
        end
        // Errors leave the stack alone; it is discarded when the result is acknowledged.
        if (err_code != ERR_NONE) begin
          stack_d      = stack_q;
          count_d      = count_q;
          output_stb_d = 1'b1;
          output_dat_d = '0;
          output_err_d = err_code;
          state_d      = OUT;
        end
      end
      OUT: begin
        if (output_ack) begin
          output_stb_d = 1'b0;
          output_err_d = ERR_NONE;
          count_d      = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tok_dat_q    <= '0;
      tok_op_q     <= 1'b0;
      input_ack_q  <= 1'b0;
      output_stb_q <= 1'b0;
      output_dat_q <= '0;
      output_err_q <= ERR_NONE;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      tok_dat_q    <= tok_dat_d;
      tok_op_q     <= tok_op_d;
      input_ack_q  <= input_ack_d;
      output_stb_q <= output_stb_d;
      output_dat_q <= output_dat_d;
      output_err_q <= output_err_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign input_ack   = input_ack_q;
  assign output_stb  = output_stb_q;
  assign output_dat  = output_dat_q;
  assign output_err  = output_err_q;
  assign stack_count = count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Directed bench for rpn_stack_calc (WIDTH=32, DEPTH=4): token driver tasks,
// an expected-result queue popped per '=' or error, and a final summary line.
module tb_rpn_stack_calc;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  localparam logic [2:0] OP_ILL  = 3'd0;
  localparam logic [2:0] OP_MUL  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_EQ   = 3'd4;
  localparam logic [2:0] OP_DUP  = 3'd5;
  localparam logic [2:0] OP_SWAP = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  logic          clk = 1'b0;
  logic          rst;
  logic          input_stb;
  logic [W-1:0]  input_dat;
  logic          input_operator;
  logic          input_ack;
  logic          output_stb;
  logic [W-1:0]  output_dat;
  logic [1:0]    output_err;
  logic          output_ack;
  logic [CW-1:0] stack_count;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [W+1:0] exp_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  rpn_stack_calc #(.WIDTH(W), .DEPTH(D)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .input_stb      (input_stb),
    .input_dat      (input_dat),
    .input_operator (input_operator),
    .input_ack      (input_ack),
    .output_stb     (output_stb),
    .output_dat     (output_dat),
    .output_err     (output_err),
    .output_ack     (output_ack),
    .stack_count    (stack_count),
    .dbg_state      (dbg_state)
  );

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Driver tasks
  task automatic wait_ack();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!input_ack && n < 20);
    if (!input_ack) check("ack_timeout", W'(input_ack), W'(1));
    input_stb = 1'b0;
  endtask

  task automatic send(input logic op, input logic [W-1:0] dat);
    input_stb      = 1'b1;
    input_operator = op;
    input_dat      = dat;
    wait_ack();
  endtask

  task automatic num(input logic [W-1:0] v);
    send(1'b0, v);
  endtask

  task automatic opc(input logic [2:0] o);
    send(1'b1, W'(o));
  endtask

  task automatic expect_res(input logic [1:0] err, input logic [W-1:0] dat);
    exp_q.push_back({err, dat});
  endtask

  // Scoreboard: waits for output_stb, compares against the queue head, optionally
  // holds output_ack low for hold cycles, then acknowledges.
  task automatic result(input int hold);
    logic [W+1:0] e;
    int n = 0;
    e = exp_q.pop_front();
    do begin
      tick();
      n++;
    end while (!output_stb && n < 20);
    if (!output_stb) begin
      check("stb_timeout", W'(output_stb), W'(1));
    end else begin
      check("latency", W'(n), W'(1));
      check("out_dat", output_dat, e[W-1:0]);
      check("out_err", W'(output_err), W'(e[W+1:W]));
      for (int i = 0; i < hold; i++) begin
        tick();
        check("hold_stb", W'(output_stb), W'(1));
        check("hold_dat", output_dat, e[W-1:0]);
        check("hold_err", W'(output_err), W'(e[W+1:W]));
        check("hold_iack", W'(input_ack), W'(0));
      end
      output_ack = 1'b1;
      tick();
      output_ack = 1'b0;
      check("stb_after_ack", W'(output_stb), W'(0));
      check("err_after_ack", W'(output_err), W'(0));
      check("cnt_after_ack", W'(stack_count), W'(0));
    end
  endtask

  initial begin
    rst            = 1'b1;
    input_stb      = 1'b0;
    input_dat      = '0;
    input_operator = 1'b0;
    output_ack     = 1'b0;
    #1;
    check("rst_iack", W'(input_ack), W'(0));
    check("rst_stb", W'(output_stb), W'(0));
    check("rst_dat", output_dat, W'(0));
    check("rst_err", W'(output_err), W'(0));
    check("rst_cnt", W'(stack_count), W'(0));
    check("rst_state", W'(dbg_state), W'(0));
    tick();
    tick();
    rst = 1'b0;

    // (3 + 4) * 2 = 14, with stack_count tracking
    num(32'd3);
    tick();
    check("cnt_one", W'(stack_count), W'(1));
    num(32'd4);
    tick();
    check("cnt_two", W'(stack_count), W'(2));
    opc(OP_ADD);
    tick();
    check("cnt_add", W'(stack_count), W'(1));
    num(32'd2);
    opc(OP_MUL);
    opc(OP_EQ);
    expect_res(2'd0, 32'd14);
    result(0);

    // 5 - 7 = -2; 0x7FFFFFFF + 1 wraps
    num(32'd5); num(32'd7); opc(OP_SUB); opc(OP_EQ);
    expect_res(2'd0, 32'hFFFF_FFFE);
    result(0);
    num(32'h7FFF_FFFF); num(32'd1); opc(OP_ADD); opc(OP_EQ);
    expect_res(2'd0, 32'h8000_0000);
    result(0);

    // -3 * 5 = -15
    num(32'hFFFF_FFFD); num(32'd5); opc(OP_MUL); opc(OP_EQ);
    expect_res(2'd0, 32'hFFFF_FFF1);
    result(0);

    // Overflow on fifth push at DEPTH=4, then recovery
    num(32'd1); num(32'd2); num(32'd3); num(32'd4);
    tick();
    check("cnt_full", W'(stack_count), W'(4));
    num(32'd5);
    expect_res(2'd2, 32'd0);
    result(0);
    num(32'd9); opc(OP_EQ);
    expect_res(2'd0, 32'd9);
    result(0);

    // DUP overflow on a full stack
    num(32'd1); num(32'd2); num(32'd3); num(32'd4); opc(OP_DUP);
    expect_res(2'd2, 32'd0);
    result(0);

    // Underflow / bad cases
    num(32'd6); opc(OP_ADD);
    expect_res(2'd1, 32'd0);
    result(0);
    num(32'd1); num(32'd2); opc(OP_EQ);
    expect_res(2'd3, 32'd0);
    result(0);
    opc(OP_ILL);
    expect_res(2'd3, 32'd0);
    result(0);
    opc(OP_EQ);
    expect_res(2'd1, 32'd0);
    result(0);
    num(32'd4); opc(OP_SWAP);
    expect_res(2'd1, 32'd0);
    result(0);
    opc(OP_DUP);
    expect_res(2'd1, 32'd0);
    result(0);

    // DUP, SWAP, CLR
    num(32'd8); opc(OP_DUP); opc(OP_MUL); opc(OP_EQ);
    expect_res(2'd0, 32'd64);
    result(0);
    num(32'd1); num(32'd2); opc(OP_SWAP); opc(OP_SUB); opc(OP_EQ);
    expect_res(2'd0, 32'd1);
    result(0);
    num(32'd1); num(32'd2); opc(OP_CLR);
    tick();
    check("cnt_clr", W'(stack_count), W'(0));
    check("stb_clr", W'(output_stb), W'(0));
    num(32'd7); opc(OP_EQ);
    expect_res(2'd0, 32'd7);
    result(0);

    // Held result with a pending token; token taken only after the ack
    num(32'd9); opc(OP_EQ);
    input_stb      = 1'b1;
    input_operator = 1'b0;
    input_dat      = 32'd5;
    expect_res(2'd0, 32'd9);
    result(10);
    check("no_ack_at_release", W'(input_ack), W'(0));
    wait_ack();
    opc(OP_EQ);
    expect_res(2'd0, 32'd5);
    result(0);

    // Asynchronous reset while a result is pending
    num(32'd1); opc(OP_EQ);
    tick();
    check("pre_rst_stb", W'(output_stb), W'(1));
    #2 rst = 1'b1;
    #1;
    check("async_rst_stb", W'(output_stb), W'(0));
    check("async_rst_cnt", W'(stack_count), W'(0));
    check("async_rst_err", W'(output_err), W'(0));
    #1 rst = 1'b0;
    tick();
    num(32'd2); num(32'd3); opc(OP_ADD); opc(OP_EQ);
    expect_res(2'd0, 32'd5);
    result(0);

    check("exp_q_empty", W'(exp_q.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rpn_stack_calc.md
Name: rpn_stack_calc

Overview:
- Parametrised RPN evaluator. Successor to the current fixed 32-bit calculator core.
- Sits behind the token converter. Accepts number/operator tokens over a stb/ack handshake and evaluates them on an internal stack of configurable width and depth.
- Emits the result, or a coded error, on '='.
- Adds DUP/SWAP/CLR operators, overflow/underflow detection, and a live stack-depth output.

Parameters:
- WIDTH, 32, data and stack entry width in bits (>=8)
- DEPTH, 8, stack entries (>=2)
- CW, $clog2(DEPTH+1), width of stack_count (derived, not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- input_stb  in  1  token valid
- input_dat  in  WIDTH  operand (two's complement), or opcode in bits [2:0] when input_operator=1
- input_operator  in  1  1 = token is an operator
- input_ack  out  1  one-cycle token-accept pulse
- output_stb  out  1  result/error valid, held until acknowledged
- output_dat  out  WIDTH  result value (0 on error)
- output_err  out  2  0 none, 1 underflow, 2 overflow, 3 bad opcode / unbalanced '='
- output_ack  in  1  consumer accepts result
- stack_count  out  CW  current number of stack entries

Behaviour:
- Reset values (asynchronous): input_ack=0, output_stb=0, output_dat=0, output_err=0, stack_count=0, state=IDLE. Stack contents are don't-care.
- Opcodes: 1 MUL, 2 ADD, 3 SUB, 4 EQ, 5 DUP, 6 SWAP, 7 CLR; 0 is illegal.
- States: IDLE, EXEC, OUT.
- IDLE:
  - If input_stb=1 and input_ack=0, the token is latched at the posedge and input_ack=1 for exactly that one cycle; next state EXEC.
  - The source drops input_stb after seeing input_ack. input_stb still high when back in IDLE is a new token.
- EXEC (one cycle, input_ack=0):
  - Number: count<DEPTH, so push; else error 2.
  - ADD/SUB/MUL need count>=2, else error 1. Pop b (top), then a; push a op b. SUB = a-b.
  - All arithmetic is modulo 2^WIDTH. MUL keeps the low WIDTH bits of the signed product. No saturation, no overflow flag.
  - DUP: needs count>=1 (else error 1) and count<DEPTH (else error 2); pushes a copy of the top.
  - SWAP: needs count>=2, else error 1; exchanges the top two entries.
  - CLR: count=0, no output.
  - EQ: count==1 sets output_dat=top, output_err=0, output_stb=1, then OUT. count==0 is error 1; count>1 is error 3.
  - Opcode 0: error 3.
  - Error: output_stb=1, output_dat=0, output_err=code, then OUT. The stack is left untouched until the ack.
  - Otherwise return to IDLE.
- Latency:
  - Token accept to stack update is 2 clk edges; maximum throughput is one token per 2 cycles.
  - EQ token accept to output_stb high is 2 edges.
- OUT:
  - output_stb, output_dat and output_err are held stable. No tokens are accepted (input_ack=0).
  - At the first posedge with output_ack=1: output_stb=0, output_err=0, count=0, next state IDLE.
  - output_ack while output_stb=0 is ignored.
- stack_count is registered and updates at the same edge as the stack.
- Reset mid-operation: all state is discarded immediately, including a pending output_stb. First token acceptance is possible on the first posedge after rst deasserts.

Test Plan:
- Tokens 3, 4, ADD, 2, MUL, EQ; output_ack high one cycle after stb -> output_stb=1, output_dat=14, output_err=0, stack_count=0 after ack.
- 5, 7, SUB, EQ -> output_dat=32'hFFFFFFFE (-2), output_err=0. Then 32'h7FFFFFFF, 1, ADD, EQ -> output_dat=32'h80000000 (wrap, no error).
- DEPTH=4: push 1, 2, 3, 4, 5 -> fifth token gives output_stb=1, output_err=2, output_dat=0. After ack, stack_count=0 and the next 9, EQ returns 9.
- Tokens 6, ADD -> output_err=1. Tokens 1, 2, EQ -> output_err=3. Opcode 0 -> output_err=3. Tokens 8, DUP, MUL, EQ -> 64. Tokens 1, 2, SWAP, SUB, EQ -> 1.
- Hold output_ack low for 10 cycles after an EQ result of 9 with input_stb high -> output_stb/dat/err stable, input_ack stays 0 throughout. The pending token is accepted only after the ack.
- Assert rst while in OUT with output_stb=1 -> output_stb=0, stack_count=0 immediately (no clock edge needed). Then 2, 3, ADD, EQ -> 5.
